bp_cce_dir_lru_reader: RTL and testbench

//  Sequencer in front of the CCE directory LRU extract stage. On a request it walks every
//  row of one directory set in the directory RAM (1-cycle read latency). It streams each

---
 rtl/bp_cce_dir_lru_reader.sv | 174 +++++++++++++++++
 tb/tb_bp_cce_dir_lru_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_dir_lru_reader.sv
// Directory LRU reader: walks every row of one directory set, streams each row downstream and
// latches the requesting LCE's LRU entry (found/excl/tag) onto a valid/yumi result port.
module bp_cce_dir_lru_reader #(
    parameter int num_way_groups_p   = 16,
    parameter int num_lce_p          = 4,
    parameter int assoc_p            = 8,
    parameter int tag_width_p        = 10,
    parameter int tag_sets_per_row_p = 2,
    localparam int coh_bits_lp       = 3,
    localparam int entry_width_lp    = tag_width_p + coh_bits_lp,
    localparam int row_width_p       = tag_sets_per_row_p * assoc_p * entry_width_lp,
    localparam int rows_per_set_lp   = num_lce_p / 2,
    localparam int set_width_lp      = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1,
    localparam int lce_width_lp      = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int way_width_lp      = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int addr_width_lp     = (num_way_groups_p * rows_per_set_lp > 1)
                                       ? $clog2(num_way_groups_p * rows_per_set_lp) : 1,
    localparam int row_num_width_lp  = (rows_per_set_lp > 1) ? $clog2(rows_per_set_lp) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic                          req_v_i,
    output logic                          req_ready_o,
    input  logic [set_width_lp-1:0]       req_set_i,
    input  logic [lce_width_lp-1:0]       req_lce_i,
    input  logic [way_width_lp-1:0]       req_lru_way_i,

    output logic                          ram_v_o,
    output logic [addr_width_lp-1:0]      ram_addr_o,
    input  logic [row_width_p-1:0]        ram_data_i,
    input  logic [tag_sets_per_row_p-1:0] ram_row_v_i,

    output logic                          row_v_o,
    output logic [row_width_p-1:0]        row_o,
    output logic [tag_sets_per_row_p-1:0] row_tag_v_o,
    output logic [row_num_width_lp-1:0]   row_num_o,

    output logic                          lru_v_o,
    input  logic                          lru_yumi_i,
    output logic                          lru_found_o,
    output logic                          lru_cached_excl_o,
    output logic [tag_width_p-1:0]        lru_tag_o
);

    if (tag_sets_per_row_p != 2) begin : g_bad_tag_sets
        $error("bp_cce_dir_lru_reader supports only tag_sets_per_row_p == 2");
    end

    typedef enum logic [1:0] {
        READY = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic [set_width_lp-1:0]       set_q, set_d;
    logic [lce_width_lp-1:0]       lce_q, lce_d;
    logic [way_width_lp-1:0]       way_q, way_d;
    logic [row_num_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic                          rsp_v_q, rsp_v_d;
    logic [row_num_width_lp-1:0]   rsp_num_q, rsp_num_d;
    logic                          found_q, found_d;
    logic                          excl_q, excl_d;
    logic [tag_width_p-1:0]        tag_q, tag_d;

    logic                          accept;
    logic                          last_read;
    logic                          hit;
    logic [lce_width_lp-1:0]       lce_row;
    logic [entry_width_lp-1:0]     entry;
    logic [coh_bits_lp-1:0]        entry_state;
    logic [tag_width_p-1:0]        entry_tag;

    assign accept    = (state_q == READY) && req_v_i;
    assign last_read = (rd_ptr_q == row_num_width_lp'(rows_per_set_lp - 1));
    assign lce_row   = lce_q >> 1;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= READY;
            set_q     <= '0;
            lce_q     <= '0;
            way_q     <= '0;
            rd_ptr_q  <= '0;
            rsp_v_q   <= 1'b0;
            rsp_num_q <= '0;
            found_q   <= 1'b0;
            excl_q    <= 1'b0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            lce_q     <= lce_d;
            way_q     <= way_d;
            rd_ptr_q  <= rd_ptr_d;
            rsp_v_q   <= rsp_v_d;
            rsp_num_q <= rsp_num_d;
            found_q   <= found_d;
            excl_q    <= excl_d;
            tag_q     <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            READY:   if (req_v_i)    state_d = READ;
            READ:    if (last_read)  state_d = DRAIN;
            DRAIN:                   state_d = DONE;
            DONE:    if (lru_yumi_i) state_d = READY;
            default:                 state_d = READY;
        endcase
    end

    // Tag sets are packed LSB-first, ways LSB-first within a set; each entry is {tag, state}.
    always_comb begin
        entry       = ram_data_i[(int'(lce_q[0]) * assoc_p + int'(way_q)) * entry_width_lp
                                 +: entry_width_lp];
        entry_state = entry[coh_bits_lp-1:0];
        entry_tag   = entry[entry_width_lp-1 -: tag_width_p];
        hit         = rsp_v_q && ram_row_v_i[lce_q[0]]
                      && (lce_row == lce_width_lp'(rsp_num_q));
    end

    always_comb begin
        set_d     = set_q;
        lce_d     = lce_q;
        way_d     = way_q;
        rd_ptr_d  = rd_ptr_q;
        found_d   = found_q;
        excl_d    = excl_q;
        tag_d     = tag_q;
        rsp_v_d   = (state_q == READ);
        rsp_num_d = rd_ptr_q;
        if (accept) begin
            set_d    = req_set_i;
            lce_d    = req_lce_i;
            way_d    = req_lru_way_i;
            rd_ptr_d = '0;
            found_d  = 1'b0;
            excl_d   = 1'b0;
            tag_d    = '0;
        end else if (state_q == READ) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Coherence state bit 0 marks shared copies (S, F, O); E and M are exclusive.
        if (hit) begin
            found_d = 1'b1;
            excl_d  = (|entry_state) & ~entry_state[0];
            tag_d   = entry_tag;
        end
    end

    always_comb begin
        req_ready_o       = (state_q == READY);
        ram_v_o           = (state_q == READ);
        ram_addr_o        = '0;
        if (state_q == READ) begin
            ram_addr_o = addr_width_lp'(set_q) * addr_width_lp'(rows_per_set_lp)
                         + addr_width_lp'(rd_ptr_q);
        end
        row_v_o           = rsp_v_q;
        row_o             = rsp_v_q ? ram_data_i : '0;
        row_tag_v_o       = rsp_v_q ? ram_row_v_i : '0;
        row_num_o         = rsp_v_q ? rsp_num_q : '0;
        lru_v_o           = (state_q == DONE);
        lru_found_o       = found_q;
        lru_cached_excl_o = excl_q;
        lru_tag_o         = tag_q;
    end

endmodule

// File: tb/tb_bp_cce_dir_lru_reader.sv
// Testbench for bp_cce_dir_lru_reader: directed and randomized requests against a directory
// memory model, with expected results derived from per-entry state/tag arrays.
module tb_bp_cce_dir_lru_reader;

    localparam int numWayGroups = 16;
    localparam int numLce       = 4;
    localparam int assoc        = 8;
    localparam int tagWidth     = 10;
    localparam int tagSets      = 2;
    localparam int cohBits      = 3;
    localparam int entryWidth   = tagWidth + cohBits;
    localparam int rowWidth     = tagSets * assoc * entryWidth;
    localparam int rowsPerSet   = numLce / 2;
    localparam int numRows      = numWayGroups * rowsPerSet;
    localparam int setWidth     = $clog2(numWayGroups);
    localparam int lceWidth     = $clog2(numLce);
    localparam int wayWidth     = $clog2(assoc);
    localparam int addrWidth    = $clog2(numRows);
    localparam int rowNumWidth  = (rowsPerSet > 1) ? $clog2(rowsPerSet) : 1;

    localparam logic [2:0] stI = 3'b000;
    localparam logic [2:0] stS = 3'b001;
    localparam logic [2:0] stE = 3'b010;
    localparam logic [2:0] stF = 3'b011;
    localparam logic [2:0] stM = 3'b110;
    localparam logic [2:0] stO = 3'b111;

    logic                   clock = 1'b0;
    logic                   resetN;
    logic                   reqV;
    logic                   reqReady;
    logic [setWidth-1:0]    reqSet;
    logic [lceWidth-1:0]    reqLce;
    logic [wayWidth-1:0]    reqLruWay;
    logic                   ramV;
    logic [addrWidth-1:0]   ramAddr;
    logic [rowWidth-1:0]    ramData;
    logic [tagSets-1:0]     ramRowV;
    logic                   rowV;
    logic [rowWidth-1:0]    rowData;
    logic [tagSets-1:0]     rowTagV;
    logic [rowNumWidth-1:0] rowNum;
    logic                   lruV;
    logic                   lruYumi;
    logic                   lruFound;
    logic                   lruExcl;
    logic [tagWidth-1:0]    lruTag;

    logic [2:0]             memState [numRows][tagSets][assoc];
    logic [tagWidth-1:0]    memTag   [numRows][tagSets][assoc];
    logic [tagSets-1:0]     memValid [numRows];
    logic [rowWidth-1:0]    memData  [numRows];
    logic [2:0]             legalStates [6];

    int checks = 0;
    int failures = 0;

    bp_cce_dir_lru_reader dut (
        .clk_i             (clock),
        .reset_n_i         (resetN),
        .req_v_i           (reqV),
        .req_ready_o       (reqReady),
        .req_set_i         (reqSet),
        .req_lce_i         (reqLce),
        .req_lru_way_i     (reqLruWay),
        .ram_v_o           (ramV),
        .ram_addr_o        (ramAddr),
        .ram_data_i        (ramData),
        .ram_row_v_i       (ramRowV),
        .row_v_o           (rowV),
        .row_o             (rowData),
        .row_tag_v_o       (rowTagV),
        .row_num_o         (rowNum),
        .lru_v_o           (lruV),
        .lru_yumi_i        (lruYumi),
        .lru_found_o       (lruFound),
        .lru_cached_excl_o (lruExcl),
        .lru_tag_o         (lruTag)
    );

    always #5 clock = ~clock;

    // Directory RAM model with one cycle of read latency.
    always @(posedge clock) begin
        if (ramV) begin
            ramData <= memData[ramAddr];
            ramRowV <= memValid[ramAddr];
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", name, observed, expected,
                     $time);
        end
    endtask

    function automatic logic [rowWidth-1:0] packRow(input int r);
        logic [rowWidth-1:0] row;
        row = '0;
        for (int s = 0; s < tagSets; s++)
            for (int w = 0; w < assoc; w++)
                row[(s * assoc + w) * entryWidth +: entryWidth] = {memTag[r][s][w], memState[r][s][w]};
        return row;
    endfunction

    function automatic logic isExclusive(input logic [2:0] st);
        return (st == stE) || (st == stM);
    endfunction

    task automatic randomizeSet(input int set);
        for (int r = set * rowsPerSet; r < (set + 1) * rowsPerSet; r++) begin
            for (int s = 0; s < tagSets; s++)
                for (int w = 0; w < assoc; w++) begin
                    memState[r][s][w] = legalStates[$urandom_range(0, 5)];
                    memTag[r][s][w]   = tagWidth'($urandom);
                end
            memValid[r] = tagSets'($urandom);
            memData[r]  = packRow(r);
        end
    endtask

    task automatic setEntry(input int row, input int tset, input int way, input logic [2:0] st,
                            input logic [tagWidth-1:0] tag, input logic valid);
        memState[row][tset][way] = st;
        memTag[row][tset][way]   = tag;
        memValid[row][tset]      = valid;
        memData[row]             = packRow(row);
    endtask

    // Issues one request at a negedge and follows it through to consumption of the result.
    task automatic applyStimulus(input int set, input int lce, input int way, input int hold);
        int                  baseAddr;
        int                  myRow;
        int                  mySet;
        logic                expFound;
        logic                expExcl;
        logic [tagWidth-1:0] expTag;
        baseAddr = set * rowsPerSet;
        myRow    = baseAddr + lce / 2;
        mySet    = lce % 2;
        expFound = memValid[myRow][mySet];
        expExcl  = expFound ? isExclusive(memState[myRow][mySet][way]) : 1'b0;
        expTag   = expFound ? memTag[myRow][mySet][way] : '0;

        checkOutput("ready_idle", 256'(reqReady), 256'(1));
        reqV      = 1'b1;
        reqSet    = setWidth'(set);
        reqLce    = lceWidth'(lce);
        reqLruWay = wayWidth'(way);
        @(negedge clock);
        for (int c = 1; c <= rowsPerSet + 1; c++) begin
            checkOutput("ready_busy", 256'(reqReady), 256'(0));
            checkOutput("lru_v_busy", 256'(lruV), 256'(0));
            checkOutput("ram_v", 256'(ramV), 256'(c <= rowsPerSet));
            if (c <= rowsPerSet)
                checkOutput("ram_addr", 256'(ramAddr), 256'(baseAddr + c - 1));
            checkOutput("row_v", 256'(rowV), 256'(c >= 2));
            if (c >= 2) begin
                checkOutput("row_num", 256'(rowNum), 256'(c - 2));
                checkOutput("row_data", 256'(rowData), 256'(memData[baseAddr + c - 2]));
                checkOutput("row_tag_v", 256'(rowTagV), 256'(memValid[baseAddr + c - 2]));
            end
            reqV      = 1'($urandom_range(0, 1));
            reqSet    = setWidth'($urandom);
            reqLce    = lceWidth'($urandom);
            reqLruWay = wayWidth'($urandom);
            @(negedge clock);
        end
        for (int h = 0; h <= hold; h++) begin
            checkOutput("lru_v", 256'(lruV), 256'(1));
            checkOutput("lru_found", 256'(lruFound), 256'(expFound));
            checkOutput("lru_excl", 256'(lruExcl), 256'(expExcl));
            checkOutput("lru_tag", 256'(lruTag), 256'(expTag));
            checkOutput("ready_done", 256'(reqReady), 256'(0));
            checkOutput("ram_v_done", 256'(ramV), 256'(0));
            if (h == hold) begin
                lruYumi = 1'b1;
                reqV    = 1'b0;
            end else begin
                reqV = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
        end
        lruYumi = 1'b0;
        checkOutput("lru_v_after_yumi", 256'(lruV), 256'(0));
        checkOutput("ready_after_yumi", 256'(reqReady), 256'(1));
    endtask

    initial begin
        legalStates = '{stI, stS, stE, stF, stM, stO};
        for (int s = 0; s < numWayGroups; s++) randomizeSet(s);
        ramData   = '0;
        ramRowV   = '0;
        resetN    = 1'b0;
        reqV      = 1'b0;
        reqSet    = '0;
        reqLce    = '0;
        reqLruWay = '0;
        lruYumi   = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_ready", 256'(reqReady), 256'(1));
        checkOutput("rst_ram_v", 256'(ramV), 256'(0));
        checkOutput("rst_ram_addr", 256'(ramAddr), 256'(0));
        checkOutput("rst_row_v", 256'(rowV), 256'(0));
        checkOutput("rst_row", 256'(rowData), 256'(0));
        checkOutput("rst_row_tag_v", 256'(rowTagV), 256'(0));
        checkOutput("rst_row_num", 256'(rowNum), 256'(0));
        checkOutput("rst_lru_v", 256'(lruV), 256'(0));
        checkOutput("rst_found", 256'(lruFound), 256'(0));
        checkOutput("rst_excl", 256'(lruExcl), 256'(0));
        checkOutput("rst_tag", 256'(lruTag), 256'(0));
        resetN = 1'b1;
        @(negedge clock);

        // LCE 3 lives in row 1, tag set 1 of each directory set.
        setEntry(11, 1, 2, stM, 10'h155, 1'b1);
        applyStimulus(5, 3, 2, 0);
        setEntry(11, 1, 2, stS, 10'h155, 1'b1);
        applyStimulus(5, 3, 2, 0);
        setEntry(11, 1, 2, stI, 10'h155, 1'b1);
        applyStimulus(5, 3, 2, 0);
        setEntry(11, 1, 2, stM, 10'h155, 1'b0);
        applyStimulus(5, 3, 2, 0);
        setEntry(11, 1, 2, stE, 10'h2aa, 1'b1);
        applyStimulus(5, 3, 2, 5);
        setEntry(30, 0, 7, stO, 10'h3c1, 1'b1);
        setEntry(31, 0, 7, stM, 10'h0f0, 1'b1);
        applyStimulus(15, 0, 7, 1);

        // Reset during the first read cycle aborts the walk.
        reqV      = 1'b1;
        reqSet    = setWidth'(7);
        reqLce    = lceWidth'(1);
        reqLruWay = wayWidth'(4);
        @(negedge clock);
        reqV = 1'b0;
        checkOutput("abort_ram_v_before", 256'(ramV), 256'(1));
        resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        checkOutput("abort_ram_v", 256'(ramV), 256'(0));
        checkOutput("abort_ready", 256'(reqReady), 256'(1));
        checkOutput("abort_row_v", 256'(rowV), 256'(0));
        for (int i = 0; i < 6; i++) begin
            checkOutput("abort_lru_v", 256'(lruV), 256'(0));
            @(negedge clock);
        end

        for (int i = 0; i < 40; i++) begin
            int set;
            set = $urandom_range(0, numWayGroups - 1);
            randomizeSet(set);
            applyStimulus(set, $urandom_range(0, numLce - 1), $urandom_range(0, assoc - 1),
                          $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
